demux4_frame: RTL and testbench

//  Sequenced 1-to-4 demultiplexer, the receive-side counterpart of the 4:1 select mux.
//  A stream of WIDTH-bit words is steered into lanes a,b,c,d in sel order (00,01,10,11).

---
 rtl/demux4_frame.sv | 121 ++++++++++++
 tb/tb_demux4_frame.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux4_frame.sv
`default_nettype none
// ============================================================================
//  Module      : demux4_frame
//  Description : Sequenced 1-to-4 demultiplexer. Words arriving on din are
//                steered into lanes a,b,c,d in sel order (0,1,2,3). Each
//                completed 4-word frame is presented on registered outputs
//                with a frame_valid / frame_ack handshake.
//
//  Ports
//    clk          in   1      rising-edge clock
//    reset        in   1      asynchronous, active-high reset
//    in_valid     in   1      din carries a word this cycle
//    din          in   WIDTH  input word, steered to the lane given by sel
//    sync         in   1      frame-start marker, forces the word/pointer to lane a
//    frame_ack    in   1      consumer accepts the presented frame
//    sel          out  2      lane pointer for the next accepted word
//    a,b,c,d      out  WIDTH  last completed frame, lanes 0..3
//    frame_valid  out  1      a..d hold an unacknowledged frame
//    overrun      out  1      sticky: a completed frame was dropped
//
//  Revision    : 1.0  initial release
// ============================================================================
module demux4_frame #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] din,
    input  logic             sync,
    input  logic             frame_ack,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic             frame_valid,
    output logic             overrun
);

    localparam logic [1:0] C_LANE_A = 2'd0;
    localparam logic [1:0] C_LANE_B = 2'd1;
    localparam logic [1:0] C_LANE_C = 2'd2;
    localparam logic [1:0] C_LANE_D = 2'd3;

    logic [1:0]       r_sel;
    logic [WIDTH-1:0] r_sh0;
    logic [WIDTH-1:0] r_sh1;
    logic [WIDTH-1:0] r_sh2;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_c;
    logic [WIDTH-1:0] r_d;
    logic             r_frame_valid;
    logic             r_overrun;

    logic [1:0]       w_lane;
    logic             w_complete;
    logic             w_transfer;

    // sync restarts the frame: the current word (if any) lands in lane a.
    assign w_lane     = sync ? C_LANE_A : r_sel;
    assign w_complete = in_valid && (w_lane == C_LANE_D);
    // A completed frame may replace the presented one only if the slot is
    // free or is being acknowledged on this very edge.
    assign w_transfer = w_complete && (!r_frame_valid || frame_ack);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel         <= C_LANE_A;
            r_sh0         <= '0;
            r_sh1         <= '0;
            r_sh2         <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_c           <= '0;
            r_d           <= '0;
            r_frame_valid <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            // Lane pointer and shadow capture
            if (in_valid) begin
                case (w_lane)
                    C_LANE_A: r_sh0 <= din;
                    C_LANE_B: r_sh1 <= din;
                    C_LANE_C: r_sh2 <= din;
                    default:  ;
                endcase
                // Lane d wraps the 2-bit pointer back to a naturally.
                r_sel <= w_lane + 2'd1;
            end else if (sync) begin
                // Abandon the partial frame; shadow contents are simply
                // overwritten by the next frame.
                r_sel <= C_LANE_A;
            end

            // Frame presentation and handshake
            if (w_transfer) begin
                r_a           <= r_sh0;
                r_b           <= r_sh1;
                r_c           <= r_sh2;
                r_d           <= din;
                r_frame_valid <= 1'b1;
            end else if (w_complete) begin
                r_overrun     <= 1'b1;
            end else if (frame_ack) begin
                r_frame_valid <= 1'b0;
            end
        end
    end

    assign sel         = r_sel;
    assign a           = r_a;
    assign b           = r_b;
    assign c           = r_c;
    assign d           = r_d;
    assign frame_valid = r_frame_valid;
    assign overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_demux4_frame.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux4_frame
//  Description : Self-checking bench for demux4_frame. Directed scenarios
//                compare against literal frames; a randomized run compares
//                every cycle against a queue-based frame model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_demux4_frame;

    localparam int W  = 8;
    localparam int VW = 2 + 4 * W + 2;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic [W-1:0] din;
    logic         sync;
    logic         frame_ack;
    logic [1:0]   sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [W-1:0] d;
    logic         frame_valid;
    logic         overrun;

    int checks = 0;
    int errors = 0;

    demux4_frame #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .din        (din),
        .sync       (sync),
        .frame_ack  (frame_ack),
        .sel        (sel),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .frame_valid(frame_valid),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [W-1:0] m_part[$];
    logic [W-1:0] m_out[4];
    logic         m_valid;
    logic         m_ovr;

    function automatic void model_reset();
        m_part.delete();
        for (int i = 0; i < 4; i++) m_out[i] = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endfunction

    function automatic void model_edge(input logic iv, input logic s,
                                       input logic ack, input logic [W-1:0] dv);
        logic was_valid;
        logic done;
        was_valid = m_valid;
        done      = 1'b0;
        if (s) m_part.delete();
        if (iv) begin
            if (m_part.size() == 3) begin
                done = 1'b1;
                if (!was_valid || ack) begin
                    m_out[0] = m_part[0];
                    m_out[1] = m_part[1];
                    m_out[2] = m_part[2];
                    m_out[3] = dv;
                    m_valid  = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
                m_part.delete();
            end else begin
                m_part.push_back(dv);
            end
        end
        if (ack && was_valid && !done) m_valid = 1'b0;
    endfunction

    function automatic logic [VW-1:0] model_vec();
        logic [1:0] ms;
        ms = 2'(m_part.size());
        return {ms, m_out[0], m_out[1], m_out[2], m_out[3], m_valid, m_ovr};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {sel, a, b, c, d, frame_valid, overrun};
    endfunction

    function automatic logic [VW-1:0] lit(input logic [1:0] s,
                                          input logic [W-1:0] la, input logic [W-1:0] lb,
                                          input logic [W-1:0] lc, input logic [W-1:0] ld,
                                          input logic fv, input logic ov);
        return {s, la, lb, lc, ld, fv, ov};
    endfunction

    // ---------------- stimulus primitives ----------------
    task automatic step(input logic iv, input logic s, input logic ack,
                        input logic [W-1:0] dv);
        in_valid  = iv;
        sync      = s;
        frame_ack = ack;
        din       = dv;
        model_edge(iv, s, ack, dv);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        sync      = 1'b0;
        frame_ack = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [VW-1:0] exp;
        // Build up state: completed frame, dropped frame, partial frame.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'h11);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'h22);
        step(1'b1, 1'b0, 1'b0, 8'h33);
        step(1'b1, 1'b0, 1'b0, 8'h44);
        exp = lit(2'b10, 8'h11, 8'h11, 8'h11, 8'h11, 1'b1, 1'b1);
        checks++;
        if (dut_vec() !== exp) begin
            errors++;
            $display("FAIL reset_pre actual=%h expected=%h", dut_vec(), exp);
        end
        // Asynchronous reset mid-cycle: must take effect before any edge.
        reset = 1'b1;
        #2;
        exp = lit(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        checks++;
        if (dut_vec() !== exp) begin
            errors++;
            $display("FAIL reset_async actual=%h expected=%h", dut_vec(), exp);
        end
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        // Partial frame was discarded: a fresh frame starts at lane a.
        step(1'b1, 1'b0, 1'b0, 8'h05);
        step(1'b1, 1'b0, 1'b0, 8'h06);
        step(1'b1, 1'b0, 1'b0, 8'h07);
        step(1'b1, 1'b0, 1'b0, 8'h08);
        exp = lit(2'b00, 8'h05, 8'h06, 8'h07, 8'h08, 1'b1, 1'b0);
        checks++;
        if (dut_vec() !== exp) begin
            errors++;
            $display("FAIL reset_after actual=%h expected=%h", dut_vec(), exp);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] words[4];
        logic [VW-1:0] exp;
        words = '{8'd0, 8'd1, 8'd0, 8'd1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, words[i]);
            checks++;
            if (sel !== 2'((i + 1) % 4)) begin
                errors++;
                $display("FAIL basic_sel%0d actual=%0d expected=%0d", i, sel, (i + 1) % 4);
            end
        end
        exp = lit(2'b00, 8'd0, 8'd1, 8'd0, 8'd1, 1'b1, 1'b0);
        checks++;
        if (dut_vec() !== exp) begin
            errors++;
            $display("FAIL basic_frame actual=%h expected=%h", dut_vec(), exp);
        end
    endtask

    task automatic test_handshake();
        logic [VW-1:0] exp;
        // Frame 0,1,0,1 from test_basic is still presented and unacked.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'd1);
        exp = lit(2'b00, 8'd0, 8'd1, 8'd0, 8'd1, 1'b1, 1'b1);
        checks++;
        if (dut_vec() !== exp) begin
            errors++;
            $display("FAIL handshake_drop actual=%h expected=%h", dut_vec(), exp);
        end
        step(1'b0, 1'b0, 1'b1, 8'd0);
        exp = lit(2'b00, 8'd0, 8'd1, 8'd0, 8'd1, 1'b0, 1'b1);
        checks++;
        if (dut_vec() !== exp) begin
            errors++;
            $display("FAIL handshake_ack actual=%h expected=%h", dut_vec(), exp);
        end
        // Ack while nothing is presented is ignored.
        step(1'b0, 1'b0, 1'b1, 8'd0);
        checks++;
        if (dut_vec() !== exp) begin
            errors++;
            $display("FAIL handshake_idle_ack actual=%h expected=%h", dut_vec(), exp);
        end
    endtask

    task automatic test_ack_complete();
        logic [VW-1:0] exp;
        do_reset();
        step(1'b1, 1'b0, 1'b0, 8'd0);
        step(1'b1, 1'b0, 1'b0, 8'd1);
        step(1'b1, 1'b0, 1'b0, 8'd0);
        step(1'b1, 1'b0, 1'b0, 8'd1);
        step(1'b1, 1'b0, 1'b0, 8'd1);
        step(1'b1, 1'b0, 1'b0, 8'd0);
        step(1'b1, 1'b0, 1'b0, 8'd1);
        step(1'b1, 1'b0, 1'b1, 8'd0);
        exp = lit(2'b00, 8'd1, 8'd0, 8'd1, 8'd0, 1'b1, 1'b0);
        checks++;
        if (dut_vec() !== exp) begin
            errors++;
            $display("FAIL ack_complete actual=%h expected=%h", dut_vec(), exp);
        end
    endtask

    task automatic test_resync();
        logic [VW-1:0] exp;
        do_reset();
        step(1'b1, 1'b0, 1'b0, 8'd1);
        step(1'b1, 1'b0, 1'b0, 8'd1);
        checks++;
        if (sel !== 2'b10) begin
            errors++;
            $display("FAIL resync_pre actual=%0d expected=2", sel);
        end
        step(1'b1, 1'b1, 1'b0, 8'd0);
        checks++;
        if (sel !== 2'b01) begin
            errors++;
            $display("FAIL resync_word actual=%0d expected=1", sel);
        end
        step(1'b1, 1'b0, 1'b0, 8'd1);
        step(1'b1, 1'b0, 1'b0, 8'd0);
        step(1'b1, 1'b0, 1'b0, 8'd1);
        exp = lit(2'b00, 8'd0, 8'd1, 8'd0, 8'd1, 1'b1, 1'b0);
        checks++;
        if (dut_vec() !== exp) begin
            errors++;
            $display("FAIL resync_frame actual=%h expected=%h", dut_vec(), exp);
        end
        // sync without a word just rewinds the pointer.
        step(1'b1, 1'b0, 1'b1, 8'h0a);
        step(1'b1, 1'b0, 1'b0, 8'h0b);
        step(1'b1, 1'b0, 1'b0, 8'h0c);
        step(1'b0, 1'b1, 1'b0, 8'hff);
        checks++;
        if (sel !== 2'b00) begin
            errors++;
            $display("FAIL resync_idle actual=%0d expected=0", sel);
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
        exp = lit(2'b00, 8'h40, 8'h41, 8'h42, 8'h43, 1'b1, 1'b0);
        checks++;
        if (dut_vec() !== exp) begin
            errors++;
            $display("FAIL resync_next actual=%h expected=%h", dut_vec(), exp);
        end
    endtask

    task automatic test_gaps();
        logic [W-1:0] words[4];
        logic [VW-1:0] exp;
        words = '{8'd0, 8'd1, 8'd0, 8'd1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, words[i]);
            for (int g = 0; g < int'($urandom_range(1, 3)); g++)
                step(1'b0, 1'b0, 1'b0, 8'($urandom));
            checks++;
            if (sel !== 2'((i + 1) % 4)) begin
                errors++;
                $display("FAIL gaps_sel%0d actual=%0d expected=%0d", i, sel, (i + 1) % 4);
            end
        end
        exp = lit(2'b00, 8'd0, 8'd1, 8'd0, 8'd1, 1'b1, 1'b0);
        checks++;
        if (dut_vec() !== exp) begin
            errors++;
            $display("FAIL gaps_frame actual=%h expected=%h", dut_vec(), exp);
        end
    endtask

    task automatic test_random();
        logic iv, s, ack;
        logic [W-1:0] dv;
        int bad;
        bad = 0;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            iv  = ($urandom_range(0, 9) < 7);
            s   = ($urandom_range(0, 9) == 0);
            ack = ($urandom_range(0, 9) < 3);
            dv  = 8'($urandom);
            step(iv, s, ack, dv);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_cycle%0d actual=%h expected=%h", n, dut_vec(), model_vec());
            end
            if (n == 300) do_reset();
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        sync      = 1'b0;
        frame_ack = 1'b0;
        din       = '0;
        model_reset();
        @(posedge clk);
        #1;
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL reset_init actual=%h expected=%h", dut_vec(), model_vec());
        end
        reset = 1'b0;

        test_reset();
        test_basic();
        test_handshake();
        test_ack_complete();
        test_resync();
        test_gaps();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
